// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one external data-memory port between the CPU memory stage and a
//   debug/loader port. Round-robin arbitration in IDLE, one outstanding access
//   at a time; reads wait READ_LATENCY enabled cycles in READ_WAIT.
//
// Ports
//   clk, rst_n, clk_enable     clock, async active-low reset, global advance enable
//   i_cpu_* / o_cpu_*          CPU request (req/we/addr/wdata) and response
//                              (ready/rvalid/rdata)
//   i_dbg_* / o_dbg_*          debug/loader port, same meaning as the CPU port
//   o_mem_read_address         memory read address
//   o_mem_write_address/data   memory write address and data
//   o_mem_write_enable         memory write strobe (memory writes on the enabled edge)
//   i_mem_read_data            memory read data
//   o_busy                     a read is in flight
module dmem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_enable,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic                  o_cpu_ready,
  output logic                  o_cpu_rvalid,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
  output logic                  o_dbg_ready,
  output logic                  o_dbg_rvalid,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_read_address,
  output logic [ADDR_WIDTH-1:0] o_mem_write_address,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  output logic                  o_mem_write_enable,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data,
  output logic                  o_busy
);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("dmem_arbiter: READ_LATENCY must be in 1..4");
    end
  endgenerate

  typedef enum logic {IDLE, READ_WAIT} state_t;

  localparam logic       OWN_CPU = 1'b0;
  localparam logic       OWN_DBG = 1'b1;
  localparam logic [2:0] LAT     = 3'(READ_LATENCY);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic                  r_owner;
  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_cpu_rvalid;
  logic                  r_dbg_rvalid;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_dbg_rdata;

  logic                  w_grant_cpu;
  logic                  w_grant_dbg;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_win_we;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_wdata;

  // Round-robin: on a tie the port that did not win last time is granted.
  always_comb begin
    w_grant_cpu = 1'b0;
    w_grant_dbg = 1'b0;
    if (r_state == IDLE) begin
      if (i_cpu_req && (!i_dbg_req || r_last_grant == OWN_DBG)) begin
        w_grant_cpu = 1'b1;
      end else if (i_dbg_req) begin
        w_grant_dbg = 1'b1;
      end
    end
  end

  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    if (w_grant_cpu) begin
      w_win_we    = i_cpu_we;
      w_win_addr  = i_cpu_addr;
      w_win_wdata = i_cpu_wdata;
    end else if (w_grant_dbg) begin
      w_win_we    = i_dbg_we;
      w_win_addr  = i_dbg_addr;
      w_win_wdata = i_dbg_wdata;
    end
  end

  // Acceptance only happens on an enabled edge.
  assign w_accept = clk_enable && (w_grant_cpu || w_grant_dbg);
  assign w_done   = (r_state == READ_WAIT) && clk_enable && (r_cnt == 3'd1);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (w_accept && !w_win_we) w_next_state = READ_WAIT;
      READ_WAIT: if (w_done) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (clk_enable) begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= OWN_DBG;
      r_owner      <= OWN_CPU;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else if (clk_enable) begin
      r_cpu_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      if (r_state == IDLE) begin
        if (w_accept) begin
          r_last_grant <= w_grant_dbg ? OWN_DBG : OWN_CPU;
          if (!w_win_we) begin
            r_addr  <= w_win_addr;
            r_owner <= w_grant_dbg ? OWN_DBG : OWN_CPU;
            r_cnt   <= LAT;
          end
        end
      end else begin
        r_cnt <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          if (r_owner == OWN_CPU) begin
            r_cpu_rdata  <= i_mem_read_data;
            r_cpu_rvalid <= 1'b1;
          end else begin
            r_dbg_rdata  <= i_mem_read_data;
            r_dbg_rvalid <= 1'b1;
          end
        end
      end
    end
  end

  // Combinational outputs are forced to their idle values while reset is held.
  assign o_cpu_ready         = rst_n && clk_enable && w_grant_cpu;
  assign o_dbg_ready         = rst_n && clk_enable && w_grant_dbg;
  assign o_mem_write_enable  = rst_n && w_accept && w_win_we;
  assign o_mem_write_address = rst_n ? w_win_addr : '0;
  assign o_mem_write_data    = rst_n ? w_win_wdata : '0;
  assign o_mem_read_address  = !rst_n ? '0 : ((r_state == READ_WAIT) ? r_addr : w_win_addr);
  assign o_busy              = (r_state == READ_WAIT);
  assign o_cpu_rvalid        = r_cpu_rvalid;
  assign o_dbg_rvalid        = r_dbg_rvalid;
  assign o_cpu_rdata         = r_cpu_rdata;
  assign o_dbg_rdata         = r_dbg_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. Two instances share the request inputs:
//   u_dut2 (READ_LATENCY=2) and u_dut1 (READ_LATENCY=1), each with its own
//   small memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_enable;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;

  logic        cpu_ready2, cpu_rvalid2, dbg_ready2, dbg_rvalid2, mem_we2, busy2;
  logic [31:0] cpu_rdata2, dbg_rdata2, mem_wd2, mem_rd2;
  logic [7:0]  mem_ra2, mem_wa2;

  logic        cpu_ready1, cpu_rvalid1, dbg_ready1, dbg_rvalid1, mem_we1, busy1;
  logic [31:0] cpu_rdata1, dbg_rdata1, mem_wd1, mem_rd1;
  logic [7:0]  mem_ra1, mem_wa1;

  logic [31:0] mem2 [0:255];
  logic [31:0] mem1 [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.READ_LATENCY(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ready(cpu_ready2), .o_cpu_rvalid(cpu_rvalid2), .o_cpu_rdata(cpu_rdata2),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ready(dbg_ready2), .o_dbg_rvalid(dbg_rvalid2), .o_dbg_rdata(dbg_rdata2),
    .o_mem_read_address(mem_ra2), .o_mem_write_address(mem_wa2),
    .o_mem_write_data(mem_wd2), .o_mem_write_enable(mem_we2),
    .i_mem_read_data(mem_rd2), .o_busy(busy2)
  );

  dmem_arbiter #(.READ_LATENCY(1), .ADDR_WIDTH(8), .DATA_WIDTH(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ready(cpu_ready1), .o_cpu_rvalid(cpu_rvalid1), .o_cpu_rdata(cpu_rdata1),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ready(dbg_ready1), .o_dbg_rvalid(dbg_rvalid1), .o_dbg_rdata(dbg_rdata1),
    .o_mem_read_address(mem_ra1), .o_mem_write_address(mem_wa1),
    .o_mem_write_data(mem_wd1), .o_mem_write_enable(mem_we1),
    .i_mem_read_data(mem_rd1), .o_busy(busy1)
  );

  // Memory models: write on the enabled edge, read data follows the address.
  always @(posedge clk) begin
    if (clk_enable && mem_we2) mem2[mem_wa2] <= mem_wd2;
    if (clk_enable && mem_we1) mem1[mem_wa1] <= mem_wd1;
  end
  assign mem_rd2 = mem2[mem_ra2];
  assign mem_rd1 = mem1[mem_ra1];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c_req, input logic c_we, input logic [7:0] c_a,
                       input logic [31:0] c_d, input logic d_req, input logic d_we,
                       input logic [7:0] d_a, input logic [31:0] d_d);
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_d;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_a; dbg_wdata = d_d;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    clk_enable = 1'b1;
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_enable = 1'b1;
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    next_cycle();
    next_cycle();
    #1;
    checks++; if (cpu_ready2 !== 1'b0) begin errors++; $display("FAIL rst_cpu_ready got %b exp 0", cpu_ready2); end
    checks++; if (dbg_ready2 !== 1'b0) begin errors++; $display("FAIL rst_dbg_ready got %b exp 0", dbg_ready2); end
    checks++; if ({cpu_rvalid2, dbg_rvalid2} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", {cpu_rvalid2, dbg_rvalid2}); end
    checks++; if (cpu_rdata2 !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata got %h exp 0", cpu_rdata2); end
    checks++; if (dbg_rdata2 !== 32'h0) begin errors++; $display("FAIL rst_dbg_rdata got %h exp 0", dbg_rdata2); end
    checks++; if ({mem_ra2, mem_wa2} !== 16'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", {mem_ra2, mem_wa2}); end
    checks++; if ({mem_we2, mem_wd2} !== 33'h0) begin errors++; $display("FAIL rst_mem_wr got %h exp 0", {mem_we2, mem_wd2}); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy2); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    next_cycle();
    drive(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if (cpu_ready2 !== 1'b1) begin errors++; $display("FAIL wr_cpu_ready got %b exp 1", cpu_ready2); end
    checks++; if (dbg_ready2 !== 1'b0) begin errors++; $display("FAIL wr_dbg_ready got %b exp 0", dbg_ready2); end
    checks++; if (mem_we2 !== 1'b1) begin errors++; $display("FAIL wr_mem_we got %b exp 1", mem_we2); end
    checks++; if (mem_wa2 !== 8'h10) begin errors++; $display("FAIL wr_mem_wa got %h exp 10", mem_wa2); end
    checks++; if (mem_wd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem_wd got %h exp deadbeef", mem_wd2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL wr_busy got %b exp 0", busy2); end
    next_cycle();
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if ({cpu_ready2, dbg_ready2, mem_we2, busy2} !== 4'b0) begin errors++; $display("FAIL wr_idle_ctrl got %b exp 0000", {cpu_ready2, dbg_ready2, mem_we2, busy2}); end
    checks++; if ({mem_ra2, mem_wa2, mem_wd2} !== 48'h0) begin errors++; $display("FAIL wr_idle_mem got %h exp 0", {mem_ra2, mem_wa2, mem_wd2}); end
  endtask

  task automatic test_read();
    next_cycle();
    drive(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if (cpu_ready2 !== 1'b1) begin errors++; $display("FAIL rd_ready got %b exp 1", cpu_ready2); end
    checks++; if (mem_ra2 !== 8'h10) begin errors++; $display("FAIL rd_mem_ra got %h exp 10", mem_ra2); end
    checks++; if (mem_we2 !== 1'b0) begin errors++; $display("FAIL rd_mem_we got %b exp 0", mem_we2); end
    next_cycle();
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if ({busy2, cpu_ready2, cpu_rvalid2} !== 3'b100) begin errors++; $display("FAIL rd_t1 got busy/ready/rvalid %b exp 100", {busy2, cpu_ready2, cpu_rvalid2}); end
    checks++; if (mem_ra2 !== 8'h10) begin errors++; $display("FAIL rd_t1_ra got %h exp 10", mem_ra2); end
    next_cycle();
    #1;
    checks++; if ({busy2, cpu_rvalid2} !== 2'b10) begin errors++; $display("FAIL rd_t2 got busy/rvalid %b exp 10", {busy2, cpu_rvalid2}); end
    next_cycle();
    #1;
    checks++; if ({busy2, cpu_rvalid2} !== 2'b01) begin errors++; $display("FAIL rd_t3 got busy/rvalid %b exp 01", {busy2, cpu_rvalid2}); end
    checks++; if (cpu_rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_t3_rdata got %h exp deadbeef", cpu_rdata2); end
    checks++; if ({dbg_rvalid2, dbg_rdata2} !== 33'h0) begin errors++; $display("FAIL rd_t3_dbg got %h exp 0", {dbg_rvalid2, dbg_rdata2}); end
    next_cycle();
    #1;
    checks++; if (cpu_rvalid2 !== 1'b0) begin errors++; $display("FAIL rd_t4_rvalid got %b exp 0", cpu_rvalid2); end
    checks++; if (cpu_rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_t4_rdata_hold got %h exp deadbeef", cpu_rdata2); end
  endtask

  task automatic test_dbg_read_blocks_cpu();
    next_cycle();
    drive(0, 0, 8'h00, 32'h0, 1, 0, 8'h10, 32'h0);
    #1;
    checks++; if ({dbg_ready2, cpu_ready2} !== 2'b10) begin errors++; $display("FAIL blk_a0 got dbg/cpu ready %b exp 10", {dbg_ready2, cpu_ready2}); end
    next_cycle();
    drive(1, 1, 8'h20, 32'h12345678, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if ({cpu_ready2, mem_we2, busy2} !== 3'b001) begin errors++; $display("FAIL blk_a1 got ready/we/busy %b exp 001", {cpu_ready2, mem_we2, busy2}); end
    next_cycle();
    #1;
    checks++; if ({cpu_ready2, mem_we2} !== 2'b00) begin errors++; $display("FAIL blk_a2 got ready/we %b exp 00", {cpu_ready2, mem_we2}); end
    next_cycle();
    #1;
    checks++; if ({dbg_rvalid2, cpu_ready2, mem_we2} !== 3'b111) begin errors++; $display("FAIL blk_a3 got rvalid/ready/we %b exp 111", {dbg_rvalid2, cpu_ready2, mem_we2}); end
    checks++; if (dbg_rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL blk_a3_dbg_rdata got %h exp deadbeef", dbg_rdata2); end
    checks++; if ({mem_wa2, mem_wd2} !== {8'h20, 32'h12345678}) begin errors++; $display("FAIL blk_a3_wr got %h exp 2012345678", {mem_wa2, mem_wd2}); end
    checks++; if (cpu_rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL blk_a3_cpu_hold got %h exp deadbeef", cpu_rdata2); end
    next_cycle();
    drive(1, 0, 8'h20, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if ({cpu_ready2, dbg_rvalid2} !== 2'b10) begin errors++; $display("FAIL raw_grant got ready/dbg_rvalid %b exp 10", {cpu_ready2, dbg_rvalid2}); end
    next_cycle();
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    next_cycle();
    next_cycle();
    #1;
    checks++; if (cpu_rvalid2 !== 1'b1) begin errors++; $display("FAIL raw_rvalid got %b exp 1", cpu_rvalid2); end
    checks++; if (cpu_rdata2 !== 32'h12345678) begin errors++; $display("FAIL raw_rdata got %h exp 12345678", cpu_rdata2); end
    checks++; if (dbg_rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_dbg_hold got %h exp deadbeef", dbg_rdata2); end
  endtask

  task automatic test_alternate();
    logic exp_cpu;
    do_reset();
    drive(1, 1, 8'h01, 32'h11, 1, 1, 8'h02, 32'h22);
    for (int i = 0; i < 4; i++) begin
      exp_cpu = (i % 2 == 0);
      #1;
      checks++; if ({cpu_ready2, dbg_ready2} !== {exp_cpu, ~exp_cpu}) begin errors++; $display("FAIL alt_%0d got cpu/dbg ready %b exp %b", i, {cpu_ready2, dbg_ready2}, {exp_cpu, ~exp_cpu}); end
      checks++; if (mem_wa2 !== (exp_cpu ? 8'h01 : 8'h02)) begin errors++; $display("FAIL alt_wa_%0d got %h exp %h", i, mem_wa2, exp_cpu ? 8'h01 : 8'h02); end
      next_cycle();
    end
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
  endtask

  task automatic test_clk_enable();
    do_reset();
    drive(1, 1, 8'h30, 32'hA5A50001, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if ({cpu_ready1, mem_we1} !== 2'b11) begin errors++; $display("FAIL ce_wr got ready/we %b exp 11", {cpu_ready1, mem_we1}); end
    next_cycle();
    drive(1, 0, 8'h30, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if (cpu_ready1 !== 1'b1) begin errors++; $display("FAIL ce_rd_ready got %b exp 1", cpu_ready1); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      clk_enable = 1'b0;
      drive(0, 0, 8'h00, 32'h0, 1, 1, 8'h50, 32'h55);
      #1;
      checks++; if ({busy1, cpu_rvalid1, dbg_ready1, mem_we1} !== 4'b1000) begin errors++; $display("FAIL ce_low_%0d got busy/rvalid/ready/we %b exp 1000", i, {busy1, cpu_rvalid1, dbg_ready1, mem_we1}); end
    end
    next_cycle();
    clk_enable = 1'b1;
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if ({busy1, cpu_rvalid1} !== 2'b10) begin errors++; $display("FAIL ce_resume got busy/rvalid %b exp 10", {busy1, cpu_rvalid1}); end
    next_cycle();
    clk_enable = 1'b0;
    drive(1, 1, 8'h40, 32'h77, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if ({cpu_rvalid1, busy1} !== 2'b10) begin errors++; $display("FAIL ce_rvalid got rvalid/busy %b exp 10", {cpu_rvalid1, busy1}); end
    checks++; if (cpu_rdata1 !== 32'hA5A50001) begin errors++; $display("FAIL ce_rdata got %h exp a5a50001", cpu_rdata1); end
    checks++; if ({cpu_ready1, mem_we1} !== 2'b00) begin errors++; $display("FAIL ce_no_accept got ready/we %b exp 00", {cpu_ready1, mem_we1}); end
    checks++; if (mem_wa1 !== 8'h40) begin errors++; $display("FAIL ce_addr_mux got %h exp 40", mem_wa1); end
    next_cycle();
    #1;
    checks++; if ({cpu_rvalid1, cpu_ready1} !== 2'b10) begin errors++; $display("FAIL ce_frozen got rvalid/ready %b exp 10", {cpu_rvalid1, cpu_ready1}); end
    next_cycle();
    clk_enable = 1'b1;
    #1;
    checks++; if ({cpu_rvalid1, cpu_ready1, mem_we1} !== 3'b111) begin errors++; $display("FAIL ce_reenable got rvalid/ready/we %b exp 111", {cpu_rvalid1, cpu_ready1, mem_we1}); end
    next_cycle();
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if (cpu_rvalid1 !== 1'b0) begin errors++; $display("FAIL ce_clear got %b exp 0", cpu_rvalid1); end
    checks++; if (cpu_rdata1 !== 32'hA5A50001) begin errors++; $display("FAIL ce_hold got %h exp a5a50001", cpu_rdata1); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    drive(1, 1, 8'h60, 32'h66, 0, 0, 8'h00, 32'h0);
    next_cycle();
    drive(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if (cpu_ready2 !== 1'b1) begin errors++; $display("FAIL rmr_grant got %b exp 1", cpu_ready2); end
    next_cycle();
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    #1;
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL rmr_busy got %b exp 1", busy2); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rmr_busy_clr got %b exp 0", busy2); end
    checks++; if ({mem_ra2, cpu_rvalid2, cpu_rdata2} !== 41'h0) begin errors++; $display("FAIL rmr_outs got %h exp 0", {mem_ra2, cpu_rvalid2, cpu_rdata2}); end
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++; if ({cpu_rvalid2, busy2} !== 2'b00) begin errors++; $display("FAIL rmr_quiet_%0d got rvalid/busy %b exp 00", i, {cpu_rvalid2, busy2}); end
    end
    drive(1, 1, 8'h70, 32'h1, 1, 1, 8'h71, 32'h2);
    #1;
    checks++; if ({cpu_ready2, dbg_ready2} !== 2'b10) begin errors++; $display("FAIL rmr_tie got cpu/dbg ready %b exp 10", {cpu_ready2, dbg_ready2}); end
    next_cycle();
    #1;
    checks++; if ({cpu_ready2, dbg_ready2} !== 2'b01) begin errors++; $display("FAIL rmr_tie2 got cpu/dbg ready %b exp 01", {cpu_ready2, dbg_ready2}); end
    next_cycle();
    drive(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_dbg_read_blocks_cpu();
    test_alternate();
    test_clk_enable();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single external data-memory port (8-bit address, 32-bit data) between the CPU memory stage and a debug/loader port. Requests are arbitrated round-robin, with one outstanding access at a time. Reads complete after a fixed, parameterized memory read latency. The block sits between the pipelined CPU's stage-4 memory pins and the top-level data memory; a CPU request that is not yet accepted is the CPU's stall condition.

Parameters:
READ_LATENCY, 1, enabled cycles from read address presentation to i_mem_read_data valid; legal 1..4
ADDR_WIDTH, 8, data memory address width
DATA_WIDTH, 32, data word width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clk_enable  input  1  global advance enable; state changes only on enabled edges
i_cpu_req  input  1  CPU access request; held with attributes until o_cpu_ready
i_cpu_we  input  1  1=write, 0=read
i_cpu_addr  input  ADDR_WIDTH  CPU address
i_cpu_wdata  input  DATA_WIDTH  CPU write data
o_cpu_ready  output  1  request accepted this cycle
o_cpu_rvalid  output  1  one-cycle pulse, o_cpu_rdata valid
o_cpu_rdata  output  DATA_WIDTH  CPU read data, held until next CPU read completes
i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata, o_dbg_ready, o_dbg_rvalid, o_dbg_rdata  same directions/widths/meanings, debug port
o_mem_read_address  output  ADDR_WIDTH  memory read address
o_mem_write_address  output  ADDR_WIDTH  memory write address
o_mem_write_data  output  DATA_WIDTH  memory write data
o_mem_write_enable  output  1  memory write strobe; memory writes on the enabled edge
i_mem_read_data  input  DATA_WIDTH  memory read data
o_busy  output  1  a read is in flight (state READ_WAIT)

Behaviour:
- Reset is asynchronous, active-low, and applies to both states and outputs.
  - Reset values: state=IDLE, last_grant=DBG, all ready/rvalid/write_enable=0, rdata regs=0, mem addresses/wdata=0, o_busy=0.
- States: IDLE, READ_WAIT.
- IDLE arbitration:
  - Arbitration is combinational over the current requests.
  - Only one requester: it is granted.
  - Both requesting: the requester not equal to last_grant is granted, so the CPU wins the first tie after reset.
  - No request: nothing granted; mem addresses, wdata and write_enable driven 0.
- Grant cycle (IDLE, clk_enable=1):
  - o_<winner>_ready=1 for exactly that cycle; the loser's ready stays 0.
  - Mem address/wdata are muxed from the winner.
  - last_grant<=winner on the edge.
- Write grant:
  - o_mem_write_enable=1 in the grant cycle, with write address/data from the winner.
  - State stays IDLE; a new grant is possible the next cycle.
- Read grant:
  - Address and owner are latched.
  - Counter<=READ_LATENCY; state<=READ_WAIT.
- READ_WAIT:
  - o_mem_read_address = latched address; all ready=0; write_enable=0; o_busy=1.
  - Counter decrements on each enabled edge.
  - On the enabled edge where counter==1: capture i_mem_read_data into the owner's rdata reg, set the owner's rvalid=1, state<=IDLE.
- Latency: a read accepted in cycle T produces rvalid high in cycle T+READ_LATENCY+1. The block is IDLE in that cycle and can grant again.
- rvalid behaviour:
  - rvalid is a registered pulse, cleared on the next enabled edge.
  - Only the owner's rvalid/rdata change; the other port's rdata is held.
- clk_enable=0:
  - All registers frozen (state, counter, last_grant, rvalid, rdata).
  - All ready=0 and o_mem_write_enable=0, so no acceptance is possible.
  - Memory address outputs keep their mux values.
- Request rules:
  - A req dropped before ready is a legal withdrawal; no side effect.
  - Attributes changing while req is high and not yet granted: the values in the grant cycle are used.
- Ordering: accesses are fully serialized in grant order. A read following a write to the same address returns the written data.
- Reset mid-read: the in-flight read is discarded, no rvalid is produced, and the block returns to IDLE with the reset values above.
- READ_LATENCY outside 1..4 is an elaboration error.

Test Plan:
- Reset then CPU write addr 0x10 data 0xDEADBEEF -> o_cpu_ready=1 and o_mem_write_enable=1 in the same cycle with addr 0x10; next cycle idle, everything 0.
- CPU read addr 0x10 (memory returns 0xDEADBEEF), READ_LATENCY=2 -> ready at T, o_busy T+1..T+2, o_cpu_rvalid only at T+3, o_cpu_rdata=0xDEADBEEF, o_dbg_rdata unchanged (0).
- Both ports continuously requesting writes from reset -> grants alternate CPU, DBG, CPU, DBG; never two ready in one cycle.
- DBG read in flight while CPU requests a write -> o_cpu_ready stays 0 until the cycle DBG rvalid is high, then CPU is granted that cycle.
- clk_enable held 0 for 3 cycles during READ_WAIT with READ_LATENCY=1 -> no ready, no rvalid while low; rvalid appears one enabled cycle after the counter edge; total enabled-cycle latency unchanged.
- rst_n pulsed low mid-READ_WAIT -> outputs go to reset values immediately, no rvalid afterward, and the next simultaneous request grants the CPU first.
